// File: rtl/beta_fwd_scoreboard_pkg.sv
// Shared constants and scoreboard entry type for the Beta bypass/hazard unit.
package beta_fwd_scoreboard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;

  localparam logic [REG_AW-1:0] R31        = 5'd31;
  localparam logic [REG_AW-1:0] XP_REG_DEF = 5'd30;

  // One in-flight instruction that will write a register.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic              is_load;
  } sb_entry_t;

endpackage

// File: rtl/beta_fwd_scoreboard_if.sv
// Bundle of pipeline-side inputs and bypass outputs of the forwarding scoreboard.
interface beta_fwd_scoreboard_if #(
  parameter int unsigned NRP   = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic                 hold;
  logic                 id_valid;
  logic [AW-1:0]        id_wa;
  logic                 id_is_load;
  logic [NRP*AW-1:0]    ra;
  logic [NRP-1:0]       ra_use;
  logic [NRP*DW-1:0]    rf_rd;
  logic [DEPTH*DW-1:0]  fwd_data;
  logic [DEPTH-1:0]     stage_kill;
  logic [DEPTH-1:0]     stage_exc;
  logic [NRP*DW-1:0]    rd_data;
  logic [NRP*SW-1:0]    rd_src;
  logic                 stall;
  logic [15:0]          stall_cnt;

  modport master (
    output hold, id_valid, id_wa, id_is_load, ra, ra_use, rf_rd, fwd_data,
           stage_kill, stage_exc,
    input  rd_data, rd_src, stall, stall_cnt
  );

  modport slave (
    input  hold, id_valid, id_wa, id_is_load, ra, ra_use, rf_rd, fwd_data,
           stage_kill, stage_exc,
    output rd_data, rd_src, stall, stall_cnt
  );

endinterface

// File: rtl/beta_fwd_scoreboard_mux.sv
// Per-read-port bypass select: youngest matching stage wins, flags load-use hazard.
module beta_fwd_mux
  import beta_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned AW       = REG_AW,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned SW       = $clog2(DEPTH + 1)
) (
  input  sb_entry_t           entries [DEPTH],
  input  logic [AW-1:0]       ra,
  input  logic                ra_use,
  input  logic [DW-1:0]       rf_rd,
  input  logic [DEPTH*DW-1:0] fwd_data,
  output logic [DW-1:0]       data_c,
  output logic [SW-1:0]       src_c,
  output logic                hazard_c
);

  logic late_load;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    data_c    = rf_rd;
    src_c     = '0;
    late_load = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (entries[k].valid && (entries[k].addr == ra)) begin
        data_c    = fwd_data[k*DW +: DW];
        src_c     = SW'(k + 1);
        late_load = entries[k].is_load && (k < int'(LOAD_RDY));
      end
    end
    if (ra == R31) begin
      data_c    = '0;
      src_c     = '0;
      late_load = 1'b0;
    end
    hazard_c = late_load && ra_use;
  end

endmodule

// File: rtl/beta_fwd_scoreboard.sv
// Register-bypass and load-use hazard unit: tracks in-flight destinations and
// forwards the youngest stage result to each read port.
module beta_fwd_scoreboard
  import beta_fwd_scoreboard_pkg::*;
#(
  parameter int unsigned NRP      = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned AW       = REG_AW,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOAD_RDY = 2,
  parameter int unsigned XP_REG   = 30
) (
  input logic                  clk,
  input logic                  rst,
  beta_fwd_scoreboard_if.slave bus
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  sb_entry_t              entry_q [DEPTH];
  sb_entry_t              entry_d [DEPTH];
  logic [CNT_W-1:0]       stall_cnt_q;
  logic [CNT_W-1:0]       stall_cnt_d;
  logic [NRP-1:0]         hazard;
  logic                   stall_c;
  sb_entry_t              id_entry;
  sb_entry_t              exc_entry;

  for (genvar p = 0; p < int'(NRP); p++) begin : g_port
    beta_fwd_mux #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .DW       (DW),
      .LOAD_RDY (LOAD_RDY),
      .SW       (SW)
    ) u_mux (
      .entries  (entry_q),
      .ra       (bus.ra[p*AW +: AW]),
      .ra_use   (bus.ra_use[p]),
      .rf_rd    (bus.rf_rd[p*DW +: DW]),
      .fwd_data (bus.fwd_data),
      .data_c   (bus.rd_data[p*DW +: DW]),
      .src_c    (bus.rd_src[p*SW +: SW]),
      .hazard_c (hazard[p])
    );
  end

  assign stall_c       = |hazard;
  assign bus.stall     = stall_c;
  assign bus.stall_cnt = stall_cnt_q;

  // R31 writes are discarded at entry; exceptions overwrite the entering slot.
  always_comb begin
    id_entry.valid    = bus.id_valid && (bus.id_wa != R31);
    id_entry.addr     = bus.id_wa;
    id_entry.is_load  = bus.id_is_load;
    exc_entry.valid   = 1'b1;
    exc_entry.addr    = REG_AW'(XP_REG);
    exc_entry.is_load = 1'b0;
  end

  // Pipeline advance; a stall injects a bubble into stage 0.
  always_comb begin
    entry_d     = entry_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.hold) begin
      entry_d[0] = stall_c ? sb_entry_t'('0) : id_entry;
      for (int k = 1; k < int'(DEPTH); k++) begin
        entry_d[k] = entry_q[k-1];
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (bus.stage_exc[k]) begin
          entry_d[k] = exc_entry;
        end else if (bus.stage_kill[k]) begin
          entry_d[k].valid = 1'b0;
        end
      end
      if (stall_c && (stall_cnt_q != '1)) begin
        stall_cnt_d = CNT_W'(stall_cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        entry_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
